dmem_lsu: RTL and testbench

Load/store unit between the memory-stage control and the word-addressed data memory `dmem`. It accepts one byte-addressed RV32I load or store at a time and enforces alignment and range checks. It sign- or zero-extends sub-word loads and implements SB/SH as read-modify-write, because `dmem` only writes whole words and returns 0 while `write_en` is high. Responses are registered and reported with an error flag.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 38 +++
 rtl/dmem_lsu.sv | 121 ++++++++++++
 tb/tb_dmem_lsu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and request legality check for the load/store unit
package lsu_pkg;

  localparam int REG_DATA_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RMW_READ,
    WRITE,
    RESP
  } lsu_state_t;

  // Any illegal funct3, misalignment or word index beyond the memory flags the request.
  function automatic logic lsu_req_err(
    input logic        we,
    input logic [2:0]  funct3,
    input logic [31:0] addr,
    input logic [31:0] dmem_words
  );
    logic bad_f3;
    logic misaligned;
    logic out_of_range;
    if (we) begin
      bad_f3 = (funct3 > F3_W);
    end else begin
      bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    misaligned   = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                   ((funct3 == F3_W) && (addr[1:0] != 2'b00));
    out_of_range = ({2'b00, addr[31:2]} >= dmem_words);
    return bad_f3 || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction/extension for loads and lane merge for sub-word stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = old_word[{addr_lo, 3'b000} +: 8];
    half_sel   = old_word[{addr_lo[1], 4'b0000} +: 16];

    load_data  = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      F3_W:    load_data = old_word;
      default: load_data = '0;
    endcase

    store_word = old_word;
    case (funct3)
      F3_B:    store_word[{addr_lo, 3'b000} +: 8]     = new_data[7:0];
      F3_H:    store_word[{addr_lo[1], 4'b0000} +: 16] = new_data[15:0];
      default: store_word = new_data;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - single-outstanding RV32I load/store unit in front of a word-addressed data memory
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int DMEM_WORDS = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic                  dmem_we,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  lsu_state_t state, state_next;

  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] merged_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;

  assign req_err = lsu_req_err(req_we, req_funct3, req_addr, 32'(DMEM_WORDS));

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .old_word   (dmem_rdata),
    .new_data   (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dmem_we    = 1'b0;
    dmem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                  state_next = RESP;
          else if (!req_we)             state_next = READ;
          else if (req_funct3 == F3_W)  state_next = WRITE;
          else                          state_next = RMW_READ;
        end
      end
      READ:     state_next = RESP;
      RMW_READ: state_next = WRITE;
      WRITE: begin
        dmem_we    = 1'b1;
        dmem_wdata = (funct3_q == F3_W) ? wdata_q : merged_q;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Response data is loaded only on the cycle that leads into RESP and then held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      merged_q     <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (req_err) begin
              resp_rdata_q <= '0;
              resp_err_q   <= 1'b1;
            end
          end
        end
        READ: begin
          resp_rdata_q <= load_data;
          resp_err_q   <= 1'b0;
        end
        RMW_READ: merged_q <= store_word;
        WRITE: begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dmem_addr  = {2'b00, addr_q[DATA_WIDTH-1:2]};
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu with a behavioural word memory
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;

  always #5 clk = ~clk;

  dmem_lsu #(
    .DATA_WIDTH (32),
    .DMEM_WORDS (2048)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata)
  );

  logic [31:0] mem [0:2047] = '{default: 32'h0};

  assign dmem_rdata = (dmem_we || (dmem_addr >= 32'd2048)) ? 32'h0 : mem[dmem_addr[10:0]];

  always @(posedge clk) begin
    if (dmem_we && (dmem_addr < 32'd2048)) mem[dmem_addr[10:0]] <= dmem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;
  int last_resp_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // exp_we_pos: cycle after accept in which dmem_we is expected, 0 for no write.
  task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_we_pos);
    int k;
    int we_cnt;
    int we_pos;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    chk({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    k = 0;
    we_cnt = 0;
    we_pos = 0;
    do begin
      @(negedge clk);
      k++;
      if (!hold) req_valid = 1'b0;
      if (dmem_we) begin
        we_cnt++;
        we_pos = k;
      end
      if (req_ready) chk({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
    end while (!resp_valid && k < 8);
    chk({tag, ".latency"}, 32'(k), 32'(exp_lat));
    chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, ".rdata"}, resp_rdata, exp_rdata);
    chk({tag, ".we_count"}, 32'(we_cnt), (exp_we_pos == 0) ? 32'd0 : 32'd1);
    chk({tag, ".we_pos"}, 32'(we_pos), 32'(exp_we_pos));
    last_resp_cyc = cyc;
  endtask

  initial begin
    int prev;
    int n_resp;
    int n_we;

    #1;
    chk("reset.ready", 32'(req_ready), 32'd1);
    chk("reset.resp_valid", 32'(resp_valid), 32'd0);
    chk("reset.rdata", resp_rdata, 32'h0);
    chk("reset.err", 32'(resp_err), 32'd0);
    chk("reset.dmem_addr", dmem_addr, 32'h0);
    chk("reset.dmem_wdata", dmem_wdata, 32'h0);
    chk("reset.dmem_we", 32'(dmem_we), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op("sw",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 2, 32'h0, 1'b0, 1);
    chk("sw.mem", mem[4], 32'hDEADBEEF);
    do_op("lw",  1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 2, 32'hDEADBEEF, 1'b0, 0);

    do_op("sw_init", 1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0, 2, 32'h0, 1'b0, 1);
    do_op("sb",  1'b1, 3'b000, 32'h13, 32'h000000AA, 1'b0, 3, 32'h0, 1'b0, 2);
    chk("sb.mem", mem[4], 32'hAA223344);
    do_op("lb",  1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 2, 32'hFFFFFFAA, 1'b0, 0);
    do_op("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 2, 32'h000000AA, 1'b0, 0);

    do_op("sw_init2", 1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0, 2, 32'h0, 1'b0, 1);
    do_op("sh",  1'b1, 3'b001, 32'h12, 32'h00008001, 1'b0, 3, 32'h0, 1'b0, 2);
    chk("sh.mem", mem[4], 32'h80013344);
    do_op("lh",  1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 2, 32'hFFFF8001, 1'b0, 0);
    do_op("lhu", 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 2, 32'h00008001, 1'b0, 0);

    do_op("err_lw_mis",  1'b0, 3'b010, 32'h11,   32'h0,        1'b0, 1, 32'h0, 1'b1, 0);
    do_op("err_sh_mis",  1'b1, 3'b001, 32'h13,   32'h0000FFFF, 1'b0, 1, 32'h0, 1'b1, 0);
    do_op("err_f3_011",  1'b0, 3'b011, 32'h10,   32'h0,        1'b0, 1, 32'h0, 1'b1, 0);
    do_op("err_range",   1'b0, 3'b010, 32'h2000, 32'h0,        1'b0, 1, 32'h0, 1'b1, 0);
    chk("err.mem", mem[4], 32'h80013344);

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h10;
    req_wdata  = 32'h55;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst.dmem_we", 32'(dmem_we), 32'd0);
    chk("rst.ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst.ready_after", 32'(req_ready), 32'd1);
    n_resp = 0;
    n_we = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
      if (dmem_we) n_we++;
    end
    chk("rst.no_resp", 32'(n_resp), 32'd0);
    chk("rst.no_we", 32'(n_we), 32'd0);
    chk("rst.mem", mem[4], 32'h80013344);
    do_op("rst.lw", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 2, 32'h80013344, 1'b0, 0);

    do_op("b2b.sw", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b1, 2, 32'h0, 1'b0, 1);
    prev = last_resp_cyc;
    do_op("b2b.lw1", 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 2, 32'hCAFEF00D, 1'b0, 0);
    chk("b2b.gap_lw1", 32'(last_resp_cyc - prev), 32'd3);
    prev = last_resp_cyc;
    do_op("b2b.sb", 1'b1, 3'b000, 32'h21, 32'h00000077, 1'b1, 3, 32'h0, 1'b0, 2);
    chk("b2b.gap_sb", 32'(last_resp_cyc - prev), 32'd4);
    prev = last_resp_cyc;
    do_op("b2b.lw2", 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 2, 32'hCAFE770D, 1'b0, 0);
    chk("b2b.gap_lw2", 32'(last_resp_cyc - prev), 32'd3);
    req_valid = 1'b0;
    chk("b2b.mem", mem[8], 32'hCAFE770D);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
